wrapped_instr_adder_brent: RTL and testbench
============================================

# wrapped_instr_adder_brent

Instrumented 32-bit Brent-Kung adder wrapped for the Caravel user area. Operands, bit masks and a chained-run engine are driven over logic-analyzer (LA) bank 1/2/3. Results, status and a run-cycle counter are read back on LA outputs; carry and busy are mirrored on two GPIOs. All outputs are gated by `active`.

## Interface
- No parameters. Data width is fixed at 32 bits.
- `wb_clk_i` in 1: the single clock; all state updates on its rising edge.
- `wb_rst_n` in 1: reset, synchronous and active-low.
- `active` in 1: project select; 0 forces the inactive output values.
- `la1_data_in` in 32: command word; [2:0] opcode, [3] strobe.
- `la1_data_out` out 32: status.
- `la1_oenb` in 32: ignored.
- `la2_data_in` in 32: write data, and run length in [15:0].
- `la2_data_out` out 32: masked sum register `s_output`.
- `la2_oenb` in 32: ignored.
- `la3_data_in` in 32: B write data.
- `la3_data_out` out 32: cycle counter, or B readback (see Configuration).
- `la3_oenb` in 32: ignored.
- `io_in` in 38: ignored.
- `io_out` out 38: [8] `chain_out`, [9] busy, all other bits 0.
- `io_oeb` out 38: [9:8] = 0, all other bits 1.

## Operation
- Registers: `a_input`, `b_input`, `a_input_ext_bit_b`, `a_input_ring_bit_b`, `s_output_bit_b` (all 32 bits); `s_output` (32); `chain_out` (1); `busy`; `done`; `remaining` (16); `cycle_cnt` (32); `strobe_q`.
- Operand A into the adder: `a_input & ~a_input_ext_bit_b`. Operand B: `b_input`. Carry-in is 0.
- Adder result: 32-bit sum plus carry-out, both modulo 2^32.
- Every cycle: `s_output <= sum & ~s_output_bit_b` and `chain_out <= carry_out`.
- Command fires when `la1_data_in[3]=1` and `strobe_q=0` (rising edge). `strobe_q` is updated every cycle.
- Opcodes:
  - 0: no operation.
  - 1: A ← la2.
  - 2: B ← la3.
  - 3: ext mask ← la2.
  - 4: ring mask ← la2.
  - 5: s mask ← la2.
  - 6: start a run.
  - 7: abort.
- Start, with N = `la2_data_in[15:0]`:
  - Always clears `cycle_cnt` and `done`.
  - N=0: sets `done`; `busy` stays 0.
  - N>0: `busy=1`, `remaining=N`.
- Each busy cycle:
  - `a_input <= (a_input & a_input_ring_bit_b) | (sum & ~a_input_ring_bit_b)`.
  - `remaining--` and `cycle_cnt++`.
  - When `remaining` goes 1→0: `busy=0`, `done=1`.
- While busy, opcodes 1–6 are ignored. Opcode 7 clears `busy` and sets `done`, leaving `remaining` as is.
- Status word `la1_data_out`: [0] busy, [1] done, [2] `chain_out`, [15:3] = 0, [31:16] `remaining`.
- When `active=0`: all `la*_data_out` = 0, `io_out` = 0, `io_oeb` = all 1. Internal state keeps running.

## Timing
- Reset values:
  - `a_input`, `b_input`, `s_output`, `chain_out`, `busy`, `done`, `remaining`, `cycle_cnt`, `strobe_q` = 0.
  - Ext mask = 0 and s mask = 0.
  - Ring mask = 32'hFFFF_FFFF (feedback off).
- Command effect: the register write happens on the edge where the strobe edge is detected. `s_output` reflects the new value one cycle later.
- A held-high strobe fires only once.
- Run of N cycles: `busy` is high for exactly N clocks; `cycle_cnt` = N at completion.
- Reset asserted mid-run: returns every register to its reset value on the next edge.

## Configuration
- `INSTR_ADDER_CYCLE_COUNT_EN`:
  - Defined: `cycle_cnt` exists and drives `la3_data_out`.
  - Undefined: no counter is built and `la3_data_out = b_input`.

## Structure
- Shared package `instr_adder_pkg`: `WIDTH=32`, opcode constants (`OP_NOP` … `OP_ABORT`), and status bit indices.
- Sub-module `brent_kung_adder32`: purely combinational.
  - Inputs a, b; outputs sum, cout.
  - Generate/propagate prefix tree, log2 up-sweep plus down-sweep.

## Test plan
- Basic add: reset, A=5, B=7 → after 1 cycle `la2_data_out`=12, `chain_out`=0, status=0.
- Overflow: A=32'hFFFF_FFFF, B=1 → `la2_data_out`=0, `io_out[8]`=1, `la1_data_out[2]`=1.
- Masks:
  - Ext mask 32'h0000_00FF with A=32'h1FF, B=0 → sum 32'h100.
  - s mask 32'hFFFF_FF00 → `la2_data_out`=0.
- Chained run: ring mask 0, A=1, B=1, start N=3 → `busy` high for 3 cycles, A ends at 4, `done`=1, `la3_data_out`=3 (with macro).
- Abort and held strobe: start N=100, abort after 10 cycles → `busy`=0, `done`=1, `remaining`=90. A strobe held high for 5 cycles performs exactly one load.
- Inactive and reset mid-run: `active=0` → `io_oeb`=all 1 and all data outputs 0. `wb_rst_n`=0 during a run → `busy`=0 and all registers at reset values on the next edge.

Source files
------------

// File: rtl/instr_adder_pkg.sv
`default_nettype none
// ---- instr_adder_pkg : shared width, opcodes and status bit positions ----
// ---- rev 1.0 ----
package instr_adder_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_LOAD_A    = 3'd1,
    OP_LOAD_B    = 3'd2,
    OP_SET_EXT   = 3'd3,
    OP_SET_RING  = 3'd4,
    OP_SET_SMASK = 3'd5,
    OP_START     = 3'd6,
    OP_ABORT     = 3'd7
  } opcode_e;

  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_DONE_BIT  = 1;
  localparam int STAT_CARRY_BIT = 2;
  localparam int STAT_REM_LSB   = 16;

  localparam logic [WIDTH-1:0] RING_MASK_RESET = {WIDTH{1'b1}};

endpackage
`default_nettype wire

// File: rtl/wrapped_instr_adder_brent_if.sv
`default_nettype none
// ---- wrapped_instr_adder_brent_if : logic-analyzer and GPIO bundle ----
// ---- rev 1.0 ----
interface wrapped_instr_adder_brent_if;
  logic [31:0] la1_data_in;
  logic [31:0] la1_data_out;
  logic [31:0] la1_oenb;
  logic [31:0] la2_data_in;
  logic [31:0] la2_data_out;
  logic [31:0] la2_oenb;
  logic [31:0] la3_data_in;
  logic [31:0] la3_data_out;
  logic [31:0] la3_oenb;
  logic [37:0] io_in;
  logic [37:0] io_out;
  logic [37:0] io_oeb;

  modport slave (
    input  la1_data_in, la1_oenb, la2_data_in, la2_oenb, la3_data_in, la3_oenb, io_in,
    output la1_data_out, la2_data_out, la3_data_out, io_out, io_oeb
  );

  modport master (
    output la1_data_in, la1_oenb, la2_data_in, la2_oenb, la3_data_in, la3_oenb, io_in,
    input  la1_data_out, la2_data_out, la3_data_out, io_out, io_oeb
  );
endinterface
`default_nettype wire

// File: rtl/brent_kung_adder32.sv
`default_nettype none
// ---- brent_kung_adder32 : combinational Brent-Kung prefix adder, cin = 0 ----
// ---- rev 1.0 ----
module brent_kung_adder32
  import instr_adder_pkg::*;
(
  input  wire logic [WIDTH-1:0] a,
  input  wire logic [WIDTH-1:0] b,
  output logic      [WIDTH-1:0] sum,
  output logic                  cout
);

  localparam int LEVELS = 5;
  localparam int STAGES = 2 * LEVELS - 1;

  logic [WIDTH-1:0] gg [0:STAGES];
  logic [WIDTH-1:0] pp [0:STAGES];
  logic [WIDTH-1:0] carry;

  assign gg[0] = a & b;
  assign pp[0] = a ^ b;

  // Stages 0..4 are the up-sweep, 5..8 the down-sweep filling the gaps.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int SPAN = (s < LEVELS) ? s : (2 * LEVELS - 2 - s);
    localparam bit UP   = (s < LEVELS);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam bit MERGE = UP ? (((i + 1) % (2 << SPAN)) == 0)
                                : ((((i + 1) % (2 << SPAN)) == (1 << SPAN)) && (i >= (2 << SPAN)));
      if (MERGE) begin : g_merge
        assign gg[s+1][i] = gg[s][i] | (pp[s][i] & gg[s][i-(1<<SPAN)]);
        assign pp[s+1][i] = pp[s][i] & pp[s][i-(1<<SPAN)];
      end else begin : g_pass
        assign gg[s+1][i] = gg[s][i];
        assign pp[s+1][i] = pp[s][i];
      end
    end
  end

  assign carry = {gg[STAGES][WIDTH-2:0], 1'b0};
  assign sum   = pp[0] ^ carry;
  assign cout  = gg[STAGES][WIDTH-1];

  wire unused_prop = ^pp[STAGES];

endmodule
`default_nettype wire

// File: rtl/wrapped_instr_adder_brent.sv
`default_nettype none
// ---- wrapped_instr_adder_brent : LA-driven instrumented Brent-Kung adder ----
// ---- option INSTR_ADDER_CYCLE_COUNT_EN puts the run-cycle counter on la3 ; rev 1.0 ----
module wrapped_instr_adder_brent
  import instr_adder_pkg::*;
(
  input  wire logic wb_clk_i,
  input  wire logic wb_rst_n,
  input  wire logic active,
  wrapped_instr_adder_brent_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic             busy;
  logic [WIDTH-1:0] a_input;
  logic [WIDTH-1:0] b_input;
  logic [WIDTH-1:0] a_input_ext_bit_b;
  logic [WIDTH-1:0] a_input_ring_bit_b;
  logic [WIDTH-1:0] s_output_bit_b;
  logic [WIDTH-1:0] s_output;
  logic             chain_out;
  logic             done;
  logic [15:0]      remaining;
  logic             strobe_q;
  logic [WIDTH-1:0] a_operand;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [WIDTH-1:0] la3_view;
  logic [WIDTH-1:0] status;

  opcode_e     opcode;
  logic        fire;
  logic        load_en;
  logic        cmd_start;
  logic        cmd_abort;
  logic [15:0] run_len;

  assign opcode    = opcode_e'(bus.la1_data_in[2:0]);
  assign fire      = bus.la1_data_in[3] & ~strobe_q;
  assign run_len   = bus.la2_data_in[15:0];
  assign load_en   = fire && (state == ST_IDLE);
  assign cmd_start = load_en && (opcode == OP_START);
  assign cmd_abort = fire && (state == ST_RUN) && (opcode == OP_ABORT);

  assign a_operand = a_input & ~a_input_ext_bit_b;

  brent_kung_adder32 u_adder (
    .a    (a_operand),
    .b    (b_input),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) state <= ST_IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (cmd_start && (run_len != 16'd0)) state_next = ST_RUN;
      ST_RUN:  if (cmd_abort || (remaining == 16'd1)) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      a_input            <= '0;
      b_input            <= '0;
      a_input_ext_bit_b  <= '0;
      a_input_ring_bit_b <= RING_MASK_RESET;
      s_output_bit_b     <= '0;
      s_output           <= '0;
      chain_out          <= 1'b0;
      done               <= 1'b0;
      remaining          <= '0;
      strobe_q           <= 1'b0;
    end else begin
      strobe_q  <= bus.la1_data_in[3];
      s_output  <= sum & ~s_output_bit_b;
      chain_out <= cout;
      if (load_en) begin
        case (opcode)
          OP_LOAD_A:    a_input            <= bus.la2_data_in;
          OP_LOAD_B:    b_input            <= bus.la3_data_in;
          OP_SET_EXT:   a_input_ext_bit_b  <= bus.la2_data_in;
          OP_SET_RING:  a_input_ring_bit_b <= bus.la2_data_in;
          OP_SET_SMASK: s_output_bit_b     <= bus.la2_data_in;
          OP_START: begin
            done      <= (run_len == 16'd0);
            remaining <= run_len;
          end
          default: ;
        endcase
      end else if (busy) begin
        // Abort wins over the feedback step; remaining is frozen where it is.
        if (cmd_abort) begin
          done <= 1'b1;
        end else begin
          a_input   <= (a_input & a_input_ring_bit_b) | (sum & ~a_input_ring_bit_b);
          remaining <= remaining - 16'd1;
          if (remaining == 16'd1) done <= 1'b1;
        end
      end
    end
  end

`ifdef INSTR_ADDER_CYCLE_COUNT_EN
  logic [WIDTH-1:0] cycle_cnt;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n)               cycle_cnt <= '0;
    else if (cmd_start)          cycle_cnt <= '0;
    else if (busy && !cmd_abort) cycle_cnt <= cycle_cnt + 1'b1;
  end

  assign la3_view = cycle_cnt;
`else
  assign la3_view = b_input;
`endif

  always_comb begin
    status                 = '0;
    status[STAT_BUSY_BIT]  = busy;
    status[STAT_DONE_BIT]  = done;
    status[STAT_CARRY_BIT] = chain_out;
    status[STAT_REM_LSB +: 16] = remaining;
  end

  assign bus.la1_data_out = active ? status   : '0;
  assign bus.la2_data_out = active ? s_output : '0;
  assign bus.la3_data_out = active ? la3_view : '0;
  assign bus.io_out       = active ? {28'd0, busy, chain_out, 8'd0} : '0;
  assign bus.io_oeb       = active ? {{28{1'b1}}, 2'b00, {8{1'b1}}} : {38{1'b1}};

  wire unused_inputs = ^{bus.la1_data_in[31:4], bus.la1_oenb, bus.la2_oenb,
                         bus.la3_oenb, bus.io_in};

endmodule
`default_nettype wire

// File: tb/tb_wrapped_instr_adder_brent.sv
`default_nettype none
// ---- tb_wrapped_instr_adder_brent : scoreboard bench for the LA-driven adder ----
// ---- rev 1.0 ----
module tb_wrapped_instr_adder_brent;

  logic clk = 1'b0;
  logic rst_n;
  logic active;
  int   errors = 0;
  int   checks = 0;

  wrapped_instr_adder_brent_if bus ();

  wrapped_instr_adder_brent dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .active   (active),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] sum;
    logic        carry;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_a, m_b, m_ext, m_ring, m_smask;
  logic [37:0] oeb_on;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_ext = '0; m_ring = '1; m_smask = '0;
  endtask

  task automatic model_step();
    logic [31:0] s;
    s   = (m_a & ~m_ext) + m_b;
    m_a = (m_a & m_ring) | (s & ~m_ring);
  endtask

  task automatic push_exp(input string tag);
    logic [32:0] full;
    full = {1'b0, m_a & ~m_ext} + {1'b0, m_b};
    sb.push_back('{tag, full[31:0] & ~m_smask, full[32]});
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check(e.tag, bus.la2_data_out, e.sum);
      check({e.tag, "_carry"}, bus.io_out[8], e.carry);
    end
  endtask

  // Called at a negedge; the command fires on the next posedge, then one idle cycle.
  task automatic cmd(input logic [2:0] op, input logic [31:0] d2, input logic [31:0] d3);
    bus.la1_data_in = {28'd0, 1'b1, op};
    bus.la2_data_in = d2;
    bus.la3_data_in = d3;
    @(negedge clk);
    bus.la1_data_in[3] = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_a(input logic [31:0] v);    cmd(3'd1, v, '0); m_a = v;     endtask
  task automatic load_b(input logic [31:0] v);    cmd(3'd2, '0, v); m_b = v;     endtask
  task automatic set_ext(input logic [31:0] v);   cmd(3'd3, v, '0); m_ext = v;   endtask
  task automatic set_ring(input logic [31:0] v);  cmd(3'd4, v, '0); m_ring = v;  endtask
  task automatic set_smask(input logic [31:0] v); cmd(3'd5, v, '0); m_smask = v; endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int busy_cycles;
    logic [31:0] ra, rb;
    oeb_on = {{28{1'b1}}, 2'b00, {8{1'b1}}};
    model_reset();
    rst_n  = 1'b0;
    active = 1'b1;
    bus.la1_data_in = '0; bus.la2_data_in = '0; bus.la3_data_in = '0;
    bus.la1_oenb = '0; bus.la2_oenb = '0; bus.la3_oenb = '0; bus.io_in = '0;
    repeat (2) @(negedge clk);
    check("rst_status", bus.la1_data_out, 32'd0);
    check("rst_sum", bus.la2_data_out, 32'd0);
    check("rst_la3", bus.la3_data_out, 32'd0);
    check("rst_io_out", bus.io_out, 38'd0);
    rst_n = 1'b1;
    @(negedge clk);

    load_a(32'd5); load_b(32'd7);
    push_exp("add_5_7"); pop_check();
    check("add_status", bus.la1_data_out, 32'd0);

    load_a(32'hFFFF_FFFF); load_b(32'd1);
    push_exp("overflow"); pop_check();
    check("overflow_status", bus.la1_data_out, 32'd4);

    set_ext(32'h0000_00FF); load_a(32'h1FF); load_b(32'd0);
    push_exp("ext_mask"); pop_check();
    check("ext_mask_value", bus.la2_data_out, 32'h100);
    set_smask(32'hFFFF_FF00);
    push_exp("s_mask"); pop_check();
    set_ext('0); set_smask('0);

    for (int k = 0; k < 4; k++) begin
      ra = $urandom(); rb = $urandom();
      if (k == 0) rb = ~ra;
      load_a(ra); load_b(rb);
      push_exp($sformatf("rand_add_%0d", k)); pop_check();
    end

    // Chained run: ring mask 0 feeds the sum back into A for N=3 cycles.
    set_ring('0); load_a(32'd1); load_b(32'd1);
    bus.la2_data_in = 32'd3;
    bus.la1_data_in = {28'd0, 1'b1, 3'd6};
    @(negedge clk);
    bus.la1_data_in[3] = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 20 && bus.la1_data_out[0]; k++) begin
      busy_cycles++;
      @(negedge clk);
    end
    check("run_busy_cycles", busy_cycles, 3);
    check("run_status", bus.la1_data_out, 32'd2);
`ifdef INSTR_ADDER_CYCLE_COUNT_EN
    check("run_cycle_cnt", bus.la3_data_out, 32'd3);
`else
    check("run_b_readback", bus.la3_data_out, 32'd1);
`endif
    for (int k = 0; k < 3; k++) model_step();
    @(negedge clk);
    check("run_a_final", m_a, 32'd4);
    push_exp("run_sum"); pop_check();

    // Abort a 100-cycle run after 10 busy edges.
    cmd(3'd6, 32'd100, '0);
    repeat (9) @(negedge clk);
    cmd(3'd7, '0, '0);
    for (int k = 0; k < 10; k++) model_step();
    check("abort_status", bus.la1_data_out, (32'd90 << 16) | 32'd2);
`ifdef INSTR_ADDER_CYCLE_COUNT_EN
    check("abort_cycle_cnt", bus.la3_data_out, 32'd10);
`endif
    push_exp("abort_sum"); pop_check();

    // Held strobe: data changes while held; only the first value may load.
    set_ring('1);
    bus.la1_data_in = {28'd0, 1'b1, 3'd1};
    bus.la2_data_in = 32'd10;
    @(negedge clk);
    bus.la2_data_in = 32'd20;
    repeat (4) @(negedge clk);
    bus.la1_data_in[3] = 1'b0;
    @(negedge clk);
    m_a = 32'd10;
    push_exp("held_strobe"); pop_check();

    active = 1'b0;
    #1;
    check("inactive_la1", bus.la1_data_out, 32'd0);
    check("inactive_la2", bus.la2_data_out, 32'd0);
    check("inactive_la3", bus.la3_data_out, 32'd0);
    check("inactive_io_out", bus.io_out, 38'd0);
    check("inactive_io_oeb", bus.io_oeb, {38{1'b1}});
    active = 1'b1;
    #1;
    check("active_io_oeb", bus.io_oeb, oeb_on);
    push_exp("reactivated"); pop_check();

    // Reset in the middle of a run.
    cmd(3'd6, 32'd50, '0);
    repeat (3) @(negedge clk);
    check("busy_before_rst", bus.io_out[9], 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrun_rst_status", bus.la1_data_out, 32'd0);
    check("midrun_rst_sum", bus.la2_data_out, 32'd0);
    check("midrun_rst_la3", bus.la3_data_out, 32'd0);
    check("midrun_rst_io", bus.io_out, 38'd0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    load_a(32'h1FF); load_b(32'd1);
    push_exp("post_rst_ext"); pop_check();
    cmd(3'd6, 32'd2, '0);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) model_step();
    push_exp("post_rst_ring"); pop_check();
    check("post_rst_status", bus.la1_data_out, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
